alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the operand and result width.
REQ-002 Parameter FUNC_WIDTH, default 3, sets the ALU function-select width.
REQ-003 Parameter ILLEGAL_MASK, default 8'b1000_0100, marks function codes 2 and 7 as not implemented by the shared ALU (bit n set = code n illegal).
REQ-004 UserCLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  2  per-requester request valid (bit 0 = A, bit 1 = B).
REQ-007 req_ready  out  2  per-requester accept; a transfer occurs when valid and ready are both 1.
REQ-008 req_func_a / req_func_b  in  FUNC_WIDTH  requested ALU function.
REQ-009 req_op1_a..req_op3_a / req_op1_b..req_op3_b  in  DATA_WIDTH  operands.
REQ-010 alu_func  out  FUNC_WIDTH  function select to the shared ALU.
REQ-011 alu_data_in1 / alu_data_in2 / alu_data_in3  out  DATA_WIDTH  ALU operands.
REQ-012 alu_data_out  in  DATA_WIDTH  combinational ALU result.
REQ-013 res_valid  out  2  result valid, one-hot toward the owning requester.
REQ-014 res_ready  in  2  per-requester result accept.
REQ-015 res_data  out  DATA_WIDTH  result shared by both requesters.
REQ-016 err_illegal  out  2  one-cycle pulse when a requester presents an illegal function code.

Function
REQ-017 The pipeline shall have two stages: ISSUE, which holds the registered operands, function, and tag and drives the alu_* outputs; and RESULT, which registers alu_data_out and the tag.
REQ-018 Latency from a request transfer at edge N shall be res_valid high after edge N+2, provided no stall occurs.
REQ-019 req_ready shall be asserted only for the granted requester, and only when ISSUE is empty or advancing in the same cycle.
REQ-020 Arbitration shall be round-robin: when both requesters are valid, the grant goes to the one not granted most recently; after reset, A has priority.
REQ-021 A single valid requester shall be granted immediately, regardless of the round-robin pointer.
REQ-022 The round-robin pointer shall update only on a completed transfer, never on a mere request.
REQ-023 A request whose function code has its ILLEGAL_MASK bit set shall be consumed (req_ready=1) but not issued; err_illegal for that requester shall pulse for one cycle, and no result shall be produced.
REQ-024 ISSUE shall advance into RESULT when RESULT is empty or its owner asserts res_ready in the same cycle; otherwise ISSUE holds and the alu_* outputs remain stable.
REQ-025 RESULT shall clear when res_valid and res_ready are both high for the owning tag; res_ready of the other requester shall be ignored.
REQ-026 res_data and res_valid shall remain stable while the result is stalled.
REQ-027 With both stages full and the result stalled, req_ready shall be 00.
REQ-028 Back-to-back operation shall sustain one issue per cycle when res_ready is held high.
REQ-029 alu_func and alu_data_in* shall be driven to zero when ISSUE is empty.

Reset
REQ-030 When rst is high at a clock edge, both stages shall empty, and req_ready, res_valid, err_illegal, alu_func, alu_data_in*, and res_data shall be 0; the round-robin pointer shall select A.
REQ-031 A reset during a stall or in-flight operation shall discard all held work, and no result for that work shall appear afterwards.
REQ-032 req_ready shall be 00 during the reset cycle and may assert from the first cycle after rst deasserts.

Configuration
REQ-033 Macro ALU_SHARE_ARBITER_STATS_EN: when defined, the block shall add outputs stat_issue_a and stat_issue_b (16 bits each), which count issued (legal) operations per requester, saturate at 16'hFFFF, and reset to 0.
REQ-034 When ALU_SHARE_ARBITER_STATS_EN is not defined, those ports and counters shall not exist, and all other behaviour shall be identical.

Verification
REQ-035 Single A request, func=0, op1=5, op2=3, res_ready=1: the request shall be accepted at cycle 0, and res_valid=01 with res_data equal to the model ALU result at cycle 2.
REQ-036 A and B both valid continuously for 4 transfers: grant order shall be A,B,A,B, and res_valid shall alternate 01,10,01,10.
REQ-037 A request with func=2: err_illegal=01 for one cycle, no res_valid ever, and the following func=4 request shall complete normally.
REQ-038 res_ready=00 held for 5 cycles after 2 accepted requests: req_ready=00 from the third cycle, and res_data shall be stable; on release, both results shall arrive in order, one per cycle.
REQ-039 rst asserted while RESULT is stalled: all outputs shall be 0 the next cycle, and no stale result shall appear after release.
REQ-040 With ALU_SHARE_ARBITER_STATS_EN defined, 3 legal A issues and 1 illegal A request shall give stat_issue_a=3; forcing 65536 issues shall hold the counter at 16'hFFFF.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters share one combinational ALU.
// Round-robin arbitration feeds a two-stage pipeline: ISSUE drives the ALU inputs and
// RESULT holds the registered ALU output until its owner takes it.
// A request with an unimplemented function code is accepted and dropped, and err_illegal
// pulses for one cycle.
// Optional feature: define ALU_SHARE_ARBITER_STATS_EN to add saturating per-requester
// issue counters (stat_issue_a / stat_issue_b).
module alu_share_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FUNC_WIDTH = 3,
    parameter logic [(2**FUNC_WIDTH)-1:0] ILLEGAL_MASK = 8'b1000_0100
) (
    input  logic                  UserCLK,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [FUNC_WIDTH-1:0] req_func_a,
    input  logic [FUNC_WIDTH-1:0] req_func_b,
    input  logic [DATA_WIDTH-1:0] req_op1_a,
    input  logic [DATA_WIDTH-1:0] req_op2_a,
    input  logic [DATA_WIDTH-1:0] req_op3_a,
    input  logic [DATA_WIDTH-1:0] req_op1_b,
    input  logic [DATA_WIDTH-1:0] req_op2_b,
    input  logic [DATA_WIDTH-1:0] req_op3_b,
    output logic [FUNC_WIDTH-1:0] alu_func,
    output logic [DATA_WIDTH-1:0] alu_data_in1,
    output logic [DATA_WIDTH-1:0] alu_data_in2,
    output logic [DATA_WIDTH-1:0] alu_data_in3,
    input  logic [DATA_WIDTH-1:0] alu_data_out,
    output logic [1:0]            res_valid,
    input  logic [1:0]            res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
`ifdef ALU_SHARE_ARBITER_STATS_EN
    output logic [15:0]           stat_issue_a,
    output logic [15:0]           stat_issue_b,
`endif
    output logic [1:0]            err_illegal
);

    // ISSUE stage
    logic                  iss_vld_q;
    logic                  iss_tag_q;
    logic [FUNC_WIDTH-1:0] iss_func_q;
    logic [DATA_WIDTH-1:0] iss_op1_q;
    logic [DATA_WIDTH-1:0] iss_op2_q;
    logic [DATA_WIDTH-1:0] iss_op3_q;

    // RESULT stage
    logic                  res_vld_q;
    logic                  res_tag_q;
    logic [DATA_WIDTH-1:0] res_data_q;

    // 1 = B wins the next contended cycle (A was granted last)
    logic                  prio_b_q;
    logic [1:0]            err_q;

    logic                  grant_b;
    logic [FUNC_WIDTH-1:0] gnt_func;
    logic                  gnt_illegal;
    logic                  res_fire;
    logic                  res_free;
    logic                  iss_adv;
    logic                  iss_free;
    logic                  xfer;
    logic                  iss_load;

    // Pick the candidate requester: a lone requester wins, contention uses the pointer.
    always_comb begin
        grant_b = 1'b0;
        unique case (req_valid)
            2'b10:   grant_b = 1'b1;
            2'b11:   grant_b = prio_b_q;
            default: grant_b = 1'b0;
        endcase
    end

    // Handshake and pipeline-advance conditions.
    always_comb begin
        gnt_func    = grant_b ? req_func_b : req_func_a;
        gnt_illegal = ILLEGAL_MASK[gnt_func];
        // Only the owner's res_ready matters; the other bit is ignored.
        res_fire    = res_vld_q & res_ready[res_tag_q];
        res_free    = ~res_vld_q | res_fire;
        iss_adv     = iss_vld_q & res_free;
        iss_free    = ~iss_vld_q | iss_adv;
        req_ready   = 2'b00;
        if (!rst && iss_free && req_valid[grant_b]) begin
            req_ready = grant_b ? 2'b10 : 2'b01;
        end
        xfer        = |(req_valid & req_ready);
        iss_load    = xfer & ~gnt_illegal;
    end

    // ISSUE register: load on a legal transfer, hold while RESULT is blocked.
    always_ff @(posedge UserCLK) begin
        if (rst) begin
            iss_vld_q  <= 1'b0;
            iss_tag_q  <= 1'b0;
            iss_func_q <= '0;
            iss_op1_q  <= '0;
            iss_op2_q  <= '0;
            iss_op3_q  <= '0;
        end else if (iss_free) begin
            iss_vld_q <= iss_load;
            if (iss_load) begin
                iss_tag_q  <= grant_b;
                iss_func_q <= gnt_func;
                iss_op1_q  <= grant_b ? req_op1_b : req_op1_a;
                iss_op2_q  <= grant_b ? req_op2_b : req_op2_a;
                iss_op3_q  <= grant_b ? req_op3_b : req_op3_a;
            end
        end
    end

    // RESULT register: capture the ALU output on advance, clear when the owner accepts.
    always_ff @(posedge UserCLK) begin
        if (rst) begin
            res_vld_q  <= 1'b0;
            res_tag_q  <= 1'b0;
            res_data_q <= '0;
        end else if (iss_adv) begin
            res_vld_q  <= 1'b1;
            res_tag_q  <= iss_tag_q;
            res_data_q <= alu_data_out;
        end else if (res_fire) begin
            res_vld_q  <= 1'b0;
        end
    end

    // Round-robin pointer moves only on a completed transfer; error pulse register.
    always_ff @(posedge UserCLK) begin
        if (rst) begin
            prio_b_q <= 1'b0;
            err_q    <= 2'b00;
        end else begin
            if (xfer) begin
                prio_b_q <= ~grant_b;
            end
            err_q <= 2'b00;
            if (xfer && gnt_illegal) begin
                err_q <= grant_b ? 2'b10 : 2'b01;
            end
        end
    end

`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [15:0] stat_a_q;
    logic [15:0] stat_b_q;

    // Saturating count of legal operations entering ISSUE, per requester.
    always_ff @(posedge UserCLK) begin
        if (rst) begin
            stat_a_q <= '0;
            stat_b_q <= '0;
        end else if (iss_load) begin
            if (!grant_b && stat_a_q != 16'hFFFF) begin
                stat_a_q <= stat_a_q + 16'd1;
            end
            if (grant_b && stat_b_q != 16'hFFFF) begin
                stat_b_q <= stat_b_q + 16'd1;
            end
        end
    end

    assign stat_issue_a = stat_a_q;
    assign stat_issue_b = stat_b_q;
`endif

    // Output drive: ALU inputs and result are zero whenever their stage is empty.
    always_comb begin
        alu_func     = iss_vld_q ? iss_func_q : '0;
        alu_data_in1 = iss_vld_q ? iss_op1_q : '0;
        alu_data_in2 = iss_vld_q ? iss_op2_q : '0;
        alu_data_in3 = iss_vld_q ? iss_op3_q : '0;
        res_valid    = 2'b00;
        if (res_vld_q) begin
            res_valid = res_tag_q ? 2'b10 : 2'b01;
        end
        res_data     = res_vld_q ? res_data_q : '0;
        err_illegal  = err_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a transaction-level model (queue of in-flight operations,
// capacity two) is checked against the DUT every cycle, plus directed literal checks.
module tb_alu_share_arbiter;

    logic        UserCLK = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req_func_a, req_func_b;
    logic [31:0] req_op1_a, req_op2_a, req_op3_a;
    logic [31:0] req_op1_b, req_op2_b, req_op3_b;
    logic [2:0]  alu_func;
    logic [31:0] alu_data_in1, alu_data_in2, alu_data_in3;
    logic [31:0] alu_data_out;
    logic [1:0]  res_valid;
    logic [1:0]  res_ready;
    logic [31:0] res_data;
    logic [1:0]  err_illegal;
`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [15:0] stat_issue_a, stat_issue_b;
`endif

    always #5 UserCLK = ~UserCLK;

    alu_share_arbiter dut (
        .UserCLK      (UserCLK),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_func_a   (req_func_a),
        .req_func_b   (req_func_b),
        .req_op1_a    (req_op1_a),
        .req_op2_a    (req_op2_a),
        .req_op3_a    (req_op3_a),
        .req_op1_b    (req_op1_b),
        .req_op2_b    (req_op2_b),
        .req_op3_b    (req_op3_b),
        .alu_func     (alu_func),
        .alu_data_in1 (alu_data_in1),
        .alu_data_in2 (alu_data_in2),
        .alu_data_in3 (alu_data_in3),
        .alu_data_out (alu_data_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
`ifdef ALU_SHARE_ARBITER_STATS_EN
        .stat_issue_a (stat_issue_a),
        .stat_issue_b (stat_issue_b),
`endif
        .err_illegal  (err_illegal)
    );

    // Reference ALU, also used to drive the DUT's alu_data_out.
    function automatic logic [31:0] alu_f(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
        case (f)
            3'd0:    alu_f = a + b;
            3'd1:    alu_f = a - b;
            3'd3:    alu_f = a & b;
            3'd4:    alu_f = a | b;
            3'd5:    alu_f = a ^ b;
            3'd6:    alu_f = a + b + c;
            default: alu_f = 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_data_out = alu_f(alu_func, alu_data_in1, alu_data_in2, alu_data_in3);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic        tag;
        logic [2:0]  func;
        logic [31:0] o1, o2, o3;
        int          vis;   // first cycle the op may show as a result
    } op_t;

    localparam logic [7:0] ILL = 8'b1000_0100;

    op_t        q[$];
    int         cyc    = 0;
    logic       last_b = 1'b1;  // pretend B went last, so A wins first contention
    logic [1:0] err_m  = 2'b00;
    int         stat_a = 0;
    int         stat_b = 0;

    // Compare DUT against the model mid-cycle, then advance the model past the next edge.
    always @(negedge UserCLK) begin
        bit          in_res, has_iss, fire;
        op_t         iss, nw, hd;
        logic        g;
        logic [1:0]  e_rr, e_rv;
        logic [31:0] e_rd;
        logic [2:0]  f;

        in_res  = (q.size() > 0) && (q[0].vis <= cyc);
        e_rv    = in_res ? (q[0].tag ? 2'b10 : 2'b01) : 2'b00;
        e_rd    = in_res ? alu_f(q[0].func, q[0].o1, q[0].o2, q[0].o3) : 32'd0;
        has_iss = 1'b0;
        iss     = '{tag: 1'b0, func: 3'd0, o1: 0, o2: 0, o3: 0, vis: 0};
        if (in_res && q.size() > 1) begin
            has_iss = 1'b1;
            iss     = q[1];
        end else if (!in_res && q.size() > 0) begin
            has_iss = 1'b1;
            iss     = q[0];
        end
        fire = in_res && res_ready[q[0].tag];
        if (req_valid == 2'b11) g = ~last_b;
        else                    g = (req_valid == 2'b10);
        e_rr = 2'b00;
        if (!rst && (q.size() - int'(fire)) < 2 && req_valid[g]) e_rr = g ? 2'b10 : 2'b01;

        chk("m_req_ready", {30'd0, req_ready}, {30'd0, e_rr});
        chk("m_res_valid", {30'd0, res_valid}, {30'd0, e_rv});
        chk("m_res_data", res_data, e_rd);
        chk("m_err_illegal", {30'd0, err_illegal}, {30'd0, err_m});
        chk("m_alu_func", {29'd0, alu_func}, has_iss ? {29'd0, iss.func} : 32'd0);
        chk("m_alu_in1", alu_data_in1, has_iss ? iss.o1 : 32'd0);
        chk("m_alu_in2", alu_data_in2, has_iss ? iss.o2 : 32'd0);
        chk("m_alu_in3", alu_data_in3, has_iss ? iss.o3 : 32'd0);
`ifdef ALU_SHARE_ARBITER_STATS_EN
        chk("m_stat_a", {16'd0, stat_issue_a}, stat_a);
        chk("m_stat_b", {16'd0, stat_issue_b}, stat_b);
`endif

        if (rst) begin
            q.delete();
            last_b = 1'b1;
            err_m  = 2'b00;
            stat_a = 0;
            stat_b = 0;
        end else begin
            if (fire) begin
                void'(q.pop_front());
                if (q.size() > 0 && q[0].vis < cyc + 1) begin
                    hd     = q[0];
                    hd.vis = cyc + 1;
                    q[0]   = hd;
                end
            end
            err_m = 2'b00;
            if (e_rr != 2'b00) begin
                last_b = g;
                f      = g ? req_func_b : req_func_a;
                if (ILL[f]) begin
                    err_m = g ? 2'b10 : 2'b01;
                end else begin
                    nw.tag  = g;
                    nw.func = f;
                    nw.o1   = g ? req_op1_b : req_op1_a;
                    nw.o2   = g ? req_op2_b : req_op2_a;
                    nw.o3   = g ? req_op3_b : req_op3_a;
                    nw.vis  = cyc + 2;
                    q.push_back(nw);
                    if (g) stat_b = (stat_b < 65535) ? stat_b + 1 : 65535;
                    else   stat_a = (stat_a < 65535) ? stat_a + 1 : 65535;
                end
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge UserCLK);
        #1;
    endtask

    logic [1:0] exp_g [4];

    initial begin
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst = 1'b1; req_valid = 2'b00; res_ready = 2'b11;
        req_func_a = 3'd0; req_func_b = 3'd0;
        req_op1_a = 0; req_op2_a = 0; req_op3_a = 0;
        req_op1_b = 0; req_op2_b = 0; req_op3_b = 0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("reset_res_valid", {30'd0, res_valid}, 32'd0);
        chk("reset_res_data", res_data, 32'd0);
        chk("reset_alu_func", {29'd0, alu_func}, 32'd0);

        // Single A request: accepted now, result two cycles later.
        req_valid = 2'b01; req_func_a = 3'd0; req_op1_a = 5; req_op2_a = 3;
        #1 chk("t1_accept", {30'd0, req_ready}, 32'd1);
        step();
        req_valid = 2'b00;
        #1 chk("t1_alu_in1", alu_data_in1, 32'd5);
        chk("t1_alu_in2", alu_data_in2, 32'd3);
        chk("t1_no_res_yet", {30'd0, res_valid}, 32'd0);
        step();
        #1 chk("t1_res_valid", {30'd0, res_valid}, 32'd1);
        chk("t1_res_data", res_data, 32'd8);
        step();
        #1 chk("t1_res_cleared", {30'd0, res_valid}, 32'd0);

        // Contention from a fresh reset: A,B,A,B, one issue per cycle.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 2'b11;
        req_func_a = 3'd0; req_op1_a = 1; req_op2_a = 2;
        req_func_b = 3'd1; req_op1_b = 9; req_op2_b = 4;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) req_valid = 2'b00;
            #1;
            if (i < 4) chk("t2_grant", {30'd0, req_ready}, {30'd0, exp_g[i]});
            if (i >= 2) begin
                chk("t2_res_valid", {30'd0, res_valid}, {30'd0, exp_g[i-2]});
                chk("t2_res_data", res_data, (exp_g[i-2] == 2'b01) ? 32'd3 : 32'd5);
            end
            step();
        end

        // Illegal func=2 is consumed with an error pulse; the next func=4 completes.
        req_valid = 2'b01; req_func_a = 3'd2; req_op1_a = 7;
        #1 chk("t3_ill_accept", {30'd0, req_ready}, 32'd1);
        step();
        req_func_a = 3'd4; req_op1_a = 12; req_op2_a = 3;
        #1 chk("t3_err_pulse", {30'd0, err_illegal}, 32'd1);
        chk("t3_next_accept", {30'd0, req_ready}, 32'd1);
        step();
        req_valid = 2'b00;
        #1 chk("t3_err_gone", {30'd0, err_illegal}, 32'd0);
        chk("t3_no_res", {30'd0, res_valid}, 32'd0);
        step();
        #1 chk("t3_res_valid", {30'd0, res_valid}, 32'd1);
        chk("t3_res_data", res_data, 32'd15);
        step();

        // Result stall with both stages full.
        res_ready = 2'b00;
        req_valid = 2'b01; req_func_a = 3'd0; req_op1_a = 20; req_op2_a = 22;
        #1 chk("t4_acc_a", {30'd0, req_ready}, 32'd1);
        step();
        req_valid = 2'b11; req_func_b = 3'd5; req_op1_b = 32'hF0; req_op2_b = 32'h0F;
        #1 chk("t4_acc_b", {30'd0, req_ready}, 32'd2);
        step();
        for (int k = 0; k < 5; k++) begin
            #1 chk("t4_stall_ready", {30'd0, req_ready}, 32'd0);
            chk("t4_stall_valid", {30'd0, res_valid}, 32'd1);
            chk("t4_stall_data", res_data, 32'd42);
            chk("t4_stall_alu", alu_data_in1, 32'hF0);
            step();
        end
        res_ready = 2'b11; req_valid = 2'b00;
        #1 chk("t4_rel_a", res_data, 32'd42);
        step();
        #1 chk("t4_rel_b_valid", {30'd0, res_valid}, 32'd2);
        chk("t4_rel_b_data", res_data, 32'hFF);
        step();
        #1 chk("t4_drained", {30'd0, res_valid}, 32'd0);

        // Reset while the result is stalled discards everything.
        res_ready = 2'b00;
        req_valid = 2'b01; req_func_a = 3'd1; req_op1_a = 100; req_op2_a = 1;
        step();
        req_valid = 2'b00;
        repeat (2) step();
        #1 chk("t5_stalled", res_data, 32'd99);
        rst = 1'b1; req_valid = 2'b01;
        #1 chk("t5_rst_ready", {30'd0, req_ready}, 32'd0);
        step();
        rst = 1'b0; req_valid = 2'b00; res_ready = 2'b11;
        #1 chk("t5_res_valid", {30'd0, res_valid}, 32'd0);
        chk("t5_res_data", res_data, 32'd0);
        chk("t5_alu_in1", alu_data_in1, 32'd0);
        chk("t5_err", {30'd0, err_illegal}, 32'd0);
        repeat (3) begin
            step();
            #1 chk("t5_no_stale", {30'd0, res_valid}, 32'd0);
        end

`ifdef ALU_SHARE_ARBITER_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 2'b01; req_func_a = 3'd0;
        repeat (3) step();
        req_func_a = 3'd7;
        step();
        req_valid = 2'b00;
        repeat (3) step();
        chk("st_three", {16'd0, stat_issue_a}, 32'd3);
        req_valid = 2'b01; req_func_a = 3'd0;
        repeat (65536) step();
        req_valid = 2'b00;
        repeat (3) step();
        chk("st_saturate", {16'd0, stat_issue_a}, 32'hFFFF);
`endif

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
